// File: rtl/prom_reader.sv
`default_nettype none
// ============================================================================
// Module   : prom_reader
// Purpose  : Scans a CE_N-gated bipolar PROM end to end. For each address it
//            drives prom_a/prom_ce_n, holds them for ACCESS_CYCLES clocks,
//            samples prom_d and offers the byte on a valid/ready write port.
//            A running 16-bit checksum of accepted bytes is maintained.
// Ports    : clk, reset (sync, active high)
//            start / abort           - scan control from the boot controller
//            prom_a, prom_ce_n, prom_d - PROM socket
//            wr_valid, wr_ready, wr_addr, wr_data - downstream write port
//            busy, done, checksum    - status
// Revision : 1.0 - initial release
// ============================================================================
module prom_reader #(
    parameter int DEPTH         = 32,
    parameter int ADDR_W        = 5,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] prom_a,
    output logic              prom_ce_n,
    input  logic [DATA_W-1:0] prom_d,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       checksum
);

    // A one-clock access still needs a 1-bit counter that simply stays at 0.
    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_PUSH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(ACCESS_CYCLES - 1);

    logic [1:0]        state_q,    state_d;
    logic [ADDR_W-1:0] prom_a_q,   prom_a_d;
    logic              ce_n_q,     ce_n_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [DATA_W-1:0] wr_data_q,  wr_data_d;
    logic              done_q,     done_d;
    logic [15:0]       checksum_q, checksum_d;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            prom_a_q   <= '0;
            ce_n_q     <= 1'b1;
            cnt_q      <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            prom_a_q   <= prom_a_d;
            ce_n_q     <= ce_n_d;
            cnt_q      <= cnt_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            checksum_q <= checksum_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        prom_a_d   = prom_a_q;
        ce_n_d     = ce_n_q;
        cnt_d      = cnt_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        checksum_d = checksum_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    prom_a_d   = '0;
                    ce_n_d     = 1'b0;
                    cnt_d      = '0;
                    checksum_d = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // Address and CE_N stay frozen; only the access counter moves.
                if (cnt_q == CNT_LAST) begin
                    wr_data_d  = prom_d;
                    wr_addr_d  = prom_a_q;
                    wr_valid_d = 1'b1;
                    state_d    = S_PUSH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PUSH: begin
                if (wr_ready) begin
                    checksum_d = checksum_q + 16'(wr_data_q);
                    wr_valid_d = 1'b0;
                    if (prom_a_q == LAST_ADDR) begin
                        ce_n_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        prom_a_d = prom_a_q + ADDR_W'(1);
                        cnt_d    = '0;
                        state_d  = S_WAIT;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything above, including a same-cycle handshake,
        // so the byte in flight is neither counted nor followed by done.
        if (abort) begin
            state_d    = S_IDLE;
            prom_a_d   = '0;
            ce_n_d     = 1'b1;
            cnt_d      = '0;
            wr_valid_d = 1'b0;
            done_d     = 1'b0;
            checksum_d = checksum_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state_q == S_WAIT) || (state_q == S_PUSH);
        prom_a    = prom_a_q;
        prom_ce_n = ce_n_q;
        wr_valid  = wr_valid_q;
        wr_addr   = wr_addr_q;
        wr_data   = wr_data_q;
        done      = done_q;
        checksum  = checksum_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_prom_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prom_reader
// Purpose  : Self-checking bench for prom_reader. Two instances: ACCESS_CYCLES=2
//            (registered PROM model, one clock of delay) and ACCESS_CYCLES=1
//            (combinational PROM model). Expected byte streams, timing and
//            checksums are derived from the PROM image held in the bench.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prom_reader;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } hs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, start, abort, wr_ready;
    logic [ADDR_W-1:0] prom_a, wr_addr;
    logic              prom_ce_n, wr_valid, busy, done;
    logic [DATA_W-1:0] prom_d, wr_data;
    logic [15:0]       checksum;

    logic              start1, abort1, wr_ready1;
    logic [ADDR_W-1:0] prom_a1, wr_addr1;
    logic              prom_ce_n1, wr_valid1, busy1, done1;
    logic [DATA_W-1:0] prom_d1, wr_data1;
    logic [15:0]       checksum1;

    logic [DATA_W-1:0] img [DEPTH];
    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int rmode = 0;   // 0: ready=1, 1: random, 2: ready=0, 3: manual
    hs_t q0[$];
    hs_t q1[$];
    int done_cnt0 = 0;
    int done_cnt1 = 0;

    prom_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .prom_a(prom_a), .prom_ce_n(prom_ce_n), .prom_d(prom_d),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .checksum(checksum)
    );

    prom_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACCESS_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .prom_a(prom_a1), .prom_ce_n(prom_ce_n1), .prom_d(prom_d1),
        .wr_valid(wr_valid1), .wr_ready(wr_ready1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .busy(busy1), .done(done1), .checksum(checksum1)
    );

    // PROM models: one clock of access delay (garbage while deselected), and zero delay.
    always @(posedge clk) prom_d <= prom_ce_n ? DATA_W'($urandom) : img[prom_a];
    assign prom_d1 = prom_ce_n1 ? '0 : img[prom_a1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitors: record accepted bytes, count done pulses, check stall
    // stability and that the address is frozen across WAIT cycles.
    logic              p_stall0 = 1'b0, p_wait0 = 1'b0, p_wait1 = 1'b0;
    logic [ADDR_W-1:0] p_wa0, p_pa0, p_pa1;
    logic [DATA_W-1:0] p_wd0;

    always @(posedge clk) begin
        if (!reset) begin
            if (wr_valid && wr_ready && !abort) q0.push_back('{cyc, wr_addr, wr_data});
            if (done) done_cnt0++;
            if (p_stall0) begin
                check_value("stall_valid", 32'(wr_valid), 32'd1);
                check_value("stall_addr",  32'(wr_addr),  32'(p_wa0));
                check_value("stall_data",  32'(wr_data),  32'(p_wd0));
            end
            if (p_wait0 && busy && !wr_valid) begin
                check_value("wait_addr_frozen", 32'(prom_a), 32'(p_pa0));
                check_value("wait_ce_n", 32'(prom_ce_n), 32'd0);
            end
        end
        p_stall0 <= !reset && !abort && wr_valid && !wr_ready;
        p_wait0  <= !reset && !abort && busy && !wr_valid;
        p_wa0    <= wr_addr;
        p_wd0    <= wr_data;
        p_pa0    <= prom_a;
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (wr_valid1 && wr_ready1) q1.push_back('{cyc, wr_addr1, wr_data1});
            if (done1) done_cnt1++;
            if (p_wait1 && busy1 && !wr_valid1)
                check_value("ac1_wait_addr_frozen", 32'(prom_a1), 32'(p_pa1));
        end
        p_wait1 <= !reset && busy1 && !wr_valid1;
        p_pa1   <= prom_a1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rmode)
            0:       wr_ready = 1'b1;
            1:       wr_ready = 1'($urandom_range(0, 1));
            2:       wr_ready = 1'b0;
            default: ;
        endcase
    endtask

    function automatic logic [15:0] model_sum(input int n);
        logic [15:0] s = '0;
        for (int i = 0; i < n; i++) s = s + 16'(img[i]);
        return s;
    endfunction

    task automatic do_start(output int e0);
        start = 1'b1;
        e0 = cyc;
        tick();
        start = 1'b0;
        check_value("start_cksum_clr", 32'(checksum), 32'd0);
        check_value("start_busy", 32'(busy), 32'd1);
        check_value("start_ce_n", 32'(prom_ce_n), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 3000) begin
            tick();
            n++;
        end
        check_value({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic check_seq(input string tag, input hs_t q[$], input int e0, input int per);
        check_value({tag, "_count"}, 32'(q.size()), 32'(DEPTH));
        for (int i = 0; i < q.size() && i < DEPTH; i++) begin
            check_value({tag, "_addr"}, 32'(q[i].a), 32'(i));
            check_value({tag, "_data"}, 32'(q[i].d), 32'(img[i]));
            if (per > 0) check_value({tag, "_hs_edge"}, 32'(q[i].cyc), 32'(e0 + per * (i + 1)));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_prom_a"},   32'(prom_a),    32'd0);
        check_value({tag, "_ce_n"},     32'(prom_ce_n), 32'd1);
        check_value({tag, "_wr_valid"}, 32'(wr_valid),  32'd0);
        check_value({tag, "_wr_addr"},  32'(wr_addr),   32'd0);
        check_value({tag, "_wr_data"},  32'(wr_data),   32'd0);
        check_value({tag, "_busy"},     32'(busy),      32'd0);
        check_value({tag, "_done"},     32'(done),      32'd0);
        check_value({tag, "_checksum"}, 32'(checksum),  32'd0);
    endtask

    task automatic full_scan(input string tag, input int mode, input logic [15:0] exp_sum);
        int e0, dc;
        q0.delete();
        dc = done_cnt0;
        rmode = mode;
        tick();
        do_start(e0);
        wait_done(tag);
        if (mode == 0) check_value({tag, "_done_edge"}, 32'(cyc - 1), 32'(e0 + DEPTH * 3));
        tick();
        check_value({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_value({tag, "_done_count"}, 32'(done_cnt0 - dc), 32'd1);
        check_value({tag, "_busy_after"}, 32'(busy), 32'd0);
        check_value({tag, "_ce_n_after"}, 32'(prom_ce_n), 32'd1);
        check_value({tag, "_cksum_const"}, 32'(checksum), 32'(exp_sum));
        check_value({tag, "_cksum_model"}, 32'(checksum), 32'(model_sum(DEPTH)));
        check_seq(tag, q0, e0, (mode == 0) ? 3 : 0);
    endtask

    initial begin
        int e0, dc, n;
        reset = 1'b1; start = 1'b0; abort = 1'b0; wr_ready = 1'b1;
        start1 = 1'b0; abort1 = 1'b0; wr_ready1 = 1'b1;
        for (int i = 0; i < DEPTH; i++) img[i] = DATA_W'(7 * i + 3);
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Ready held high, exact timing.
        full_scan("scan_rdy", 0, 16'h0DF0);
        // Random back-pressure.
        full_scan("scan_rand", 1, 16'h0DF0);
        // All-ones image, then re-scan straight from DONE.
        for (int i = 0; i < DEPTH; i++) img[i] = '1;
        full_scan("scan_ff", 0, 16'h1FE0);
        full_scan("scan_ff_again", 1, 16'h1FE0);

        // Abort while stalled in PUSH of address 10.
        for (int i = 0; i < DEPTH; i++) img[i] = DATA_W'(7 * i + 3);
        rmode = 0;
        dc = done_cnt0;
        do_start(e0);
        n = 0;
        while (!(wr_valid && wr_addr == 5'd10) && n < 500) begin tick(); n++; end
        check_value("abort_reach_addr10", 32'(wr_addr), 32'd10);
        rmode = 3;
        wr_ready = 1'b0;
        tick();
        check_value("abort_stalled_valid", 32'(wr_valid), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_value("abort_ce_n", 32'(prom_ce_n), 32'd1);
        check_value("abort_valid", 32'(wr_valid), 32'd0);
        check_value("abort_busy", 32'(busy), 32'd0);
        check_value("abort_prom_a", 32'(prom_a), 32'd0);
        check_value("abort_cksum", 32'(checksum), 32'(model_sum(10)));
        repeat (4) tick();
        check_value("abort_cksum_hold", 32'(checksum), 32'(model_sum(10)));
        check_value("abort_no_done", 32'(done_cnt0 - dc), 32'd0);

        // Abort coincident with a handshake: that byte is not counted.
        rmode = 0;
        do_start(e0);
        n = 0;
        while (!(wr_valid && wr_addr == 5'd3) && n < 500) begin tick(); n++; end
        rmode = 3;
        wr_ready = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_value("abort_hs_cksum", 32'(checksum), 32'(model_sum(3)));
        check_value("abort_hs_busy", 32'(busy), 32'd0);

        // Reset in the middle of WAIT for address 5; start held during reset.
        rmode = 0;
        do_start(e0);
        n = 0;
        while (!(busy && !wr_valid && prom_a == 5'd5) && n < 500) begin tick(); n++; end
        check_value("rst_reach_wait5", 32'(prom_a), 32'd5);
        reset = 1'b1;
        start = 1'b1;
        tick();
        check_reset_outputs("midrst");
        tick();
        check_value("midrst_start_ignored", 32'(busy), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        check_value("midrst_idle", 32'(busy), 32'd0);

        // ACCESS_CYCLES=1 instance: two clocks per byte, start while busy ignored.
        q1.delete();
        dc = done_cnt1;
        start1 = 1'b1;
        e0 = cyc;
        tick();
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 500) begin
            start1 = (n == 5 || n == 20 || n == 41);
            tick();
            n++;
        end
        start1 = 1'b0;
        check_value("ac1_done_seen", 32'(done1), 32'd1);
        check_value("ac1_done_edge", 32'(cyc - 1), 32'(e0 + DEPTH * 2));
        tick();
        check_value("ac1_done_count", 32'(done_cnt1 - dc), 32'd1);
        check_value("ac1_cksum", 32'(checksum1), 32'h0DF0);
        check_value("ac1_busy_after", 32'(busy1), 32'd0);
        check_seq("ac1", q1, e0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
